// File: rtl/datapath_exec_pkg.sv
// datapath_exec_pkg
// Shared definitions for the datapath and its control unit:
//   - register command codes (what X/Y/Z do on a RUN edge)
//   - ALU opcode codes
//   - sequencer FSM state encoding
//   - command/opcode field widths
package datapath_exec_pkg;

    localparam int CMD_W = 4;
    localparam int OP_W  = 4;

    // Register commands; any other code behaves as HOLD.
    localparam logic [CMD_W-1:0] CMD_HOLD   = 4'd0;
    localparam logic [CMD_W-1:0] CMD_LOAD   = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SHIFTR = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SHIFTL = 4'd3;
    localparam logic [CMD_W-1:0] CMD_RESET  = 4'd4;

    // ALU opcodes; any other code yields 0.
    localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
    localparam logic [OP_W-1:0] OP_MAIOR = 4'd2;
    localparam logic [OP_W-1:0] OP_MENOR = 4'd3;
    localparam logic [OP_W-1:0] OP_IGUAL = 4'd4;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd5;
    localparam logic [OP_W-1:0] OP_AND   = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/datapath_exec_alu.sv
// datapath_alu
// Combinational ALU of the executing datapath. a_i is register Y,
// b_i is register X. Comparisons are unsigned and zero-extended.
// Build option DATAPATH_FLAGS_EN adds carry_o (ADD carry-out / SUB borrow).
// Ports:
//   op_i    ALU opcode
//   a_i     operand a (Y)
//   b_i     operand b (X)
//   y_o     result
//   carry_o carry/borrow (only with DATAPATH_FLAGS_EN)
module datapath_alu
    import datapath_exec_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
`ifdef DATAPATH_FLAGS_EN
    ,
    output logic             carry_o
`endif
);

`ifdef DATAPATH_FLAGS_EN
    logic [WIDTH:0] sum;
    assign sum = {1'b0, a_i} + {1'b0, b_i};
`endif

    always_comb begin
        y_o = '0;
`ifdef DATAPATH_FLAGS_EN
        carry_o = 1'b0;
`endif
        case (op_i)
            OP_ADD: begin
`ifdef DATAPATH_FLAGS_EN
                y_o     = sum[WIDTH-1:0];
                carry_o = sum[WIDTH];
`else
                y_o = a_i + b_i;
`endif
            end
            OP_SUB: begin
                y_o = a_i - b_i;
`ifdef DATAPATH_FLAGS_EN
                carry_o = (a_i < b_i);
`endif
            end
            OP_MAIOR: y_o = WIDTH'(a_i > b_i);
            OP_MENOR: y_o = WIDTH'(a_i < b_i);
            OP_IGUAL: y_o = WIDTH'(a_i == b_i);
            OP_XOR:   y_o = a_i ^ b_i;
            OP_AND:   y_o = a_i & b_i;
            default:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/datapath_exec.sv
// datapath_exec
// Executing end of the control-word interface. Owns the step counter that
// the combinational control unit decodes; one program pass runs per start
// pulse (sampled in IDLE) and ends with a one-cycle done pulse.
// Build option DATAPATH_FLAGS_EN adds zero_flag/carry_flag, captured on
// edges where Z loads from the ALU.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   start              begin a pass (IDLE only)
//   din                operand loaded into X
//   Tx, Ty, Tz         register commands for X, Y, Z
//   Tula               ALU opcode
//   count              current step, to the control unit
//   busy, done         RUN indicator, end-of-pass pulse
//   X, Y, Z            registers
//   zero_flag, carry_flag  (DATAPATH_FLAGS_EN only)
//
// state | meaning
// IDLE  | count=0, commands ignored, waits for start
// RUN   | apply commands every edge, count 0..LAST_STEP
// DONE  | done pulse for one cycle, registers hold
module datapath_exec
    import datapath_exec_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int LAST_STEP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [CMD_W-1:0] Tx,
    input  logic [CMD_W-1:0] Ty,
    input  logic [CMD_W-1:0] Tz,
    input  logic [OP_W-1:0]  Tula,
    output logic [3:0]       count,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Z
`ifdef DATAPATH_FLAGS_EN
    ,
    output logic             zero_flag,
    output logic             carry_flag
`endif
);

    localparam logic [3:0] LAST_CNT = 4'(LAST_STEP);

    state_e           state_q, state_d;
    logic [3:0]       count_q, count_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] alu_y;

    function automatic logic [WIDTH-1:0] apply_cmd(input logic [CMD_W-1:0] cmd,
                                                   input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] src);
        case (cmd)
            CMD_LOAD:   return src;
            CMD_SHIFTR: return cur >> 1;
            CMD_SHIFTL: return cur << 1;
            CMD_RESET:  return '0;
            default:    return cur;
        endcase
    endfunction

`ifdef DATAPATH_FLAGS_EN
    logic alu_carry;
    logic zero_q, carry_q;
    logic flag_ld;

    datapath_alu #(.WIDTH(WIDTH)) u_alu (
        .op_i    (Tula),
        .a_i     (y_q),
        .b_i     (x_q),
        .y_o     (alu_y),
        .carry_o (alu_carry)
    );

    assign flag_ld = (state_q == ST_RUN) && (Tz == CMD_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if (flag_ld) begin
            zero_q  <= (alu_y == '0);
            carry_q <= alu_carry;
        end
    end

    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;
`else
    datapath_alu #(.WIDTH(WIDTH)) u_alu (
        .op_i (Tula),
        .a_i  (y_q),
        .b_i  (x_q),
        .y_o  (alu_y)
    );
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                // All three update from pre-edge values through the ALU.
                x_d = apply_cmd(Tx, x_q, din);
                y_d = apply_cmd(Ty, y_q, alu_y);
                z_d = apply_cmd(Tz, z_q, alu_y);
                if (count_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    count_d = '0;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            // busy/done are registered copies of the next state.
            busy_q  <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign X     = x_q;
    assign Y     = y_q;
    assign Z     = z_q;

endmodule

// File: tb/tb_datapath_exec.sv
module tb_datapath_exec;

    localparam int W  = 4;
    localparam int LS = 4;
    localparam int M  = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] din = '0;
    logic [3:0]   Tx = '0, Ty = '0, Tz = '0, Tula = '0;
    logic [3:0]   count;
    logic         busy, done;
    logic [W-1:0] X, Y, Z;

    int errors = 0;
    int checks = 0;
    int mx, my, mz;
`ifdef DATAPATH_FLAGS_EN
    logic zero_flag, carry_flag;
    int   mzf, mcf;
`endif

    logic [3:0]   p_tx [0:LS];
    logic [3:0]   p_ty [0:LS];
    logic [3:0]   p_tz [0:LS];
    logic [3:0]   p_op [0:LS];
    logic [W-1:0] p_din[0:LS];

    always #5 clk = ~clk;

    datapath_exec #(.WIDTH(W), .LAST_STEP(LS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .din   (din),
        .Tx    (Tx),
        .Ty    (Ty),
        .Tz    (Tz),
        .Tula  (Tula),
        .count (count),
        .busy  (busy),
        .done  (done),
        .X     (X),
        .Y     (Y),
        .Z     (Z)
`ifdef DATAPATH_FLAGS_EN
        ,
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference ALU: plain integer arithmetic on unsigned values.
    function automatic int alu_ref(int op, int a, int b);
        case (op)
            0: return (a + b) % M;
            1: return (a - b + M) % M;
            2: return (a > b) ? 1 : 0;
            3: return (a < b) ? 1 : 0;
            4: return (a == b) ? 1 : 0;
            5: return a ^ b;
            6: return a & b;
            default: return 0;
        endcase
    endfunction

    function automatic int cmd_ref(int cmd, int cur, int src);
        case (cmd)
            1: return src;
            2: return cur / 2;
            3: return (cur * 2) % M;
            4: return 0;
            default: return cur;
        endcase
    endfunction

    task automatic model_step(int tx, int ty, int tz, int op, int d);
        int a;
        a = alu_ref(op, my, mx);
`ifdef DATAPATH_FLAGS_EN
        if (tz == 1) begin
            mzf = (a == 0) ? 1 : 0;
            mcf = (op == 0) ? ((my + mx >= M) ? 1 : 0) :
                  (op == 1) ? ((my < mx) ? 1 : 0) : 0;
        end
`endif
        mx = cmd_ref(tx, mx, d);
        my = cmd_ref(ty, my, a);
        mz = cmd_ref(tz, mz, a);
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_X"}, 32'(X), 32'(mx));
        chk({tag, "_Y"}, 32'(Y), 32'(my));
        chk({tag, "_Z"}, 32'(Z), 32'(mz));
`ifdef DATAPATH_FLAGS_EN
        chk({tag, "_zf"}, 32'(zero_flag), 32'(mzf));
        chk({tag, "_cf"}, 32'(carry_flag), 32'(mcf));
`endif
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mz = 0;
`ifdef DATAPATH_FLAGS_EN
        mzf = 0; mcf = 0;
`endif
    endtask

    task automatic set_step(int s, int tx, int ty, int tz, int op, int d);
        p_tx[s] = 4'(tx); p_ty[s] = 4'(ty); p_tz[s] = 4'(tz);
        p_op[s] = 4'(op); p_din[s] = W'(d);
    endtask

    task automatic clear_prog();
        for (int s = 0; s <= LS; s++) set_step(s, 0, 0, 0, 0, 0);
    endtask

    // Called at a negedge with the DUT idle. hold_start keeps start high
    // through RUN and DONE, which must not disturb the pass.
    task automatic run_pass(input bit hold_start);
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        if (!hold_start) start = 1'b0;
        for (int s = 0; s <= LS; s++) begin
            Tx = p_tx[s]; Ty = p_ty[s]; Tz = p_tz[s]; Tula = p_op[s]; din = p_din[s];
            chk("run_count", 32'(count), 32'(s));
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(done), 32'd0);
            model_step(p_tx[s], p_ty[s], p_tz[s], p_op[s], p_din[s]);
            @(posedge clk); @(negedge clk);
            check_regs("step");
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_count", 32'(count), 32'd0);
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_count", 32'(count), 32'd0);
        check_regs("idle");
    endtask

    task automatic prog_average(int d0, int d1);
        clear_prog();
        set_step(0, 1, 4, 4, 0, d0);
        set_step(1, 1, 1, 0, 0, d1);
        set_step(2, 0, 1, 0, 0, 0);
        set_step(3, 4, 2, 0, 0, 0);
        set_step(4, 0, 0, 1, 0, 0);
    endtask

    // X=bval, Y=aval after step 1.
    task automatic prog_setup(int aval, int bval);
        clear_prog();
        set_step(0, 1, 4, 0, 0, aval);
        set_step(1, 1, 1, 0, 0, bval);
    endtask

    int ops[8]       = '{0, 1, 2, 3, 4, 5, 6, 9};
    int sweep_exp[8] = '{8, M - 2, 0, 1, 0, 6, 1, 0};

    initial begin
        int e;
        bit seen;
        model_reset();
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        check_regs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Average of 6 and 4.
        prog_average(6, 4);
        run_pass(1'b0);
        chk("avg_z", 32'(Z), 32'((6 + 4) / 2));

        // Overflow: 9 + 9 wraps.
        prog_average(9, 9);
        run_pass(1'b0);
        chk("ovf_z", 32'(Z), 32'(((9 + 9) % M) / 2));

        // ALU sweep with Y=3, X=5.
        for (int k = 0; k < 8; k++) begin
            prog_setup(3, 5);
            set_step(4, 0, 0, 1, ops[k], 0);
            run_pass(1'b0);
            chk("alu_sweep", 32'(Z), 32'(sweep_exp[k]));
`ifdef DATAPATH_FLAGS_EN
            if (ops[k] == 1) begin
                chk("sub_cf", 32'(carry_flag), 32'd1);
                chk("sub_zf", 32'(zero_flag), 32'd0);
            end
`endif
        end

`ifdef DATAPATH_FLAGS_EN
        prog_setup(7, 7);
        set_step(4, 0, 0, 1, 1, 0);
        run_pass(1'b0);
        chk("eq_zf", 32'(zero_flag), 32'd1);
        chk("eq_cf", 32'(carry_flag), 32'd0);
`endif

        // Shifts and illegal command on Y=1001.
        prog_setup(9, 0);
        set_step(1, 0, 1, 0, 0, 0);
        set_step(2, 0, 3, 0, 0, 0);
        set_step(3, 0, 2, 0, 0, 0);
        set_step(4, 0, 7, 0, 0, 0);
        run_pass(1'b0);
        chk("shift_y", 32'(Y), 32'd1);

        // start held during RUN and DONE is ignored.
        prog_average(6, 4);
        run_pass(1'b1);

        // start held continuously: relaunches from the IDLE cycle.
        clear_prog();
        Tx = 0; Ty = 0; Tz = 0; Tula = 0;
        start = 1'b1;
        for (int i = 0; i < LS + 4; i++) begin
            @(posedge clk); @(negedge clk);
            if (i <= LS) begin
                chk("cont_count", 32'(count), 32'(i));
                chk("cont_busy", 32'(busy), 32'd1);
            end else if (i == LS + 1) begin
                chk("cont_done", 32'(done), 32'd1);
            end else if (i == LS + 2) begin
                chk("cont_idle", 32'(busy), 32'd0);
            end else begin
                chk("cont_restart_busy", 32'(busy), 32'd1);
                chk("cont_restart_count", 32'(count), 32'd0);
            end
        end
        start = 1'b0;
        seen = 1'b0;
        e = 0;
        while (!seen && e < 20) begin
            @(posedge clk); @(negedge clk);
            if (done) seen = 1'b1;
            e++;
        end
        chk("cont_finish", 32'(seen), 32'd1);
        @(posedge clk); @(negedge clk);
        check_regs("cont");

        // Reset in the middle of a pass.
        prog_average(6, 4);
        Tx = 1; Ty = 1; Tz = 1; Tula = 0; din = 7;
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("mid_count", 32'(count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        check_regs("mid_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_pass(1'b0);
        chk("post_rst_avg_z", 32'(Z), 32'd5);

        // Random passes against the reference model.
        for (int r = 0; r < 15; r++) begin
            for (int s = 0; s <= LS; s++)
                set_step(s, $urandom_range(0, 6), $urandom_range(0, 6),
                         $urandom_range(0, 6), $urandom_range(0, 15),
                         $urandom_range(0, M - 1));
            run_pass(1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
